// File: rtl/seg_display_source.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_source
// Purpose  : Feeds the 8-digit seven-segment scanner. Picks one of four
//            32-bit debug sources with a debounced "next" button and shows it
//            either as raw hex or as 8 packed BCD digits, produced by a
//            sequential double-dabble converter. A debounced "mode" button
//            toggles between the two displays.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_source #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd999999
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_btn_next,
  input  logic        i_btn_mode,
  input  logic [31:0] i_src0,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  input  logic [31:0] i_src3,
  output logic [31:0] o_data,
  output logic [1:0]  o_page,
  output logic        o_dec_mode,
  output logic        o_overflow
);

  // Converter states: one capture cycle, 32 shift cycles, one write cycle.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [4:0] LAST_SHIFT = 5'd31;

  // --------------------------------------------------------------------------
  // Button conditioning: bit 0 = next, bit 1 = mode
  // --------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {i_btn_mode, i_btn_next};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [1:0]  sync_q, sync_d;
    logic [19:0] cnt_q, cnt_d;
    logic        lvl_q, lvl_d;

    // Counter runs only while the synchronized level disagrees with the
    // accepted level; any bounce back to the accepted level restarts it.
    always_comb begin
      sync_d = {sync_q[0], btn_raw[g]};
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      if (sync_q[1] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == DEBOUNCE_CYCLES) begin
        lvl_d = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end

    // Synchronizer, debounce counter and accepted level registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync_q <= '0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
      end
    end

    // Press pulse on the edge where the accepted level rises; release is silent.
    assign press[g] = lvl_d & ~lvl_q;
  end

  logic next_pulse;
  logic mode_pulse;
  logic abort;

  assign next_pulse = press[0];
  assign mode_pulse = press[1];
  assign abort      = next_pulse | mode_pulse;

  // --------------------------------------------------------------------------
  // Page / mode state and display registers
  // --------------------------------------------------------------------------
  logic [1:0]  page_q, page_d;
  logic        dec_q, dec_d;
  logic [31:0] data_q, data_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] sample_q, sample_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  shcnt_q, shcnt_d;
  logic [31:0] src_sel;
  logic [39:0] bcd_adj;

  // Add 3 to every BCD nibble of 5 or more so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [39:0] bcd_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign bcd_adj = bcd_adjust(bcd_q);

  // Source multiplexer driven by the current page.
  always_comb begin
    src_sel = i_src0;
    case (page_q)
      2'd0:    src_sel = i_src0;
      2'd1:    src_sel = i_src1;
      2'd2:    src_sel = i_src2;
      default: src_sel = i_src3;
    endcase
  end

  // Page advance (wraps naturally at 2 bits) and display-mode toggle.
  always_comb begin
    page_d = page_q;
    dec_d  = dec_q;
    if (next_pulse) begin
      page_d = page_q + 2'd1;
    end
    if (mode_pulse) begin
      dec_d = ~dec_q;
    end
  end

  // Display path and double-dabble converter. In hex mode the converter is
  // parked in IDLE; in decimal mode it free-runs and any button press
  // restarts it so a stale page or mode never reaches the display.
  always_comb begin
    data_d   = data_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    sample_d = sample_q;
    bcd_d    = bcd_q;
    shcnt_d  = shcnt_q;
    if (!dec_q) begin
      state_d = ST_IDLE;
      data_d  = src_sel;
      ovf_d   = 1'b0;
    end else if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sample_d = src_sel;
          bcd_d    = '0;
          shcnt_d  = '0;
          state_d  = ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_d    = (bcd_adj << 1) | {39'd0, sample_q[31]};
          sample_d = sample_q << 1;
          shcnt_d  = shcnt_q + 5'd1;
          if (shcnt_q == LAST_SHIFT) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          // Only eight digits fit on the display; anything wider saturates.
          if (bcd_q[39:32] != 8'd0) begin
            data_d = 32'hFFFF_FFFF;
            ovf_d  = 1'b1;
          end else begin
            data_d = bcd_q[31:0];
            ovf_d  = 1'b0;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // All page, mode, display and converter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      page_q   <= '0;
      dec_q    <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      sample_q <= '0;
      bcd_q    <= '0;
      shcnt_q  <= '0;
    end else begin
      page_q   <= page_d;
      dec_q    <= dec_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      sample_q <= sample_d;
      bcd_q    <= bcd_d;
      shcnt_q  <= shcnt_d;
    end
  end

  assign o_data     = data_q;
  assign o_page     = page_q;
  assign o_dec_mode = dec_q;
  assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_source
// Purpose  : Self-checking bench for seg_display_source with a short
//            debounce window; expected display words go through a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_source;

  localparam logic [19:0] DEB = 20'd15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_mode = 1'b0;
  logic [31:0] src0 = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [31:0] src3 = '0;
  logic [31:0] data;
  logic [1:0]  page;
  logic        dec_mode;
  logic        ovf;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [1:0]  exp_page = 2'd0;

  seg_display_source #(.DEBOUNCE_CYCLES(DEB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_next (btn_next),
    .i_btn_mode (btn_mode),
    .i_src0     (src0),
    .i_src1     (src1),
    .i_src2     (src2),
    .i_src3     (src3),
    .o_data     (data),
    .o_page     (page),
    .o_dec_mode (dec_mode),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src_of(input logic [1:0] p);
    case (p)
      2'd0:    return src0;
      2'd1:    return src1;
      2'd2:    return src2;
      default: return src3;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    src0 = 32'h1111_AAAA; src1 = 32'h0539_7FB1;
    src2 = 32'h3333_CCCC; src3 = 32'h4444_DDDD;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want %h", data, 32'h0); end
    checks++; if (page !== 2'd0) begin errors++; $display("FAIL reset_page got %0d want 0", page); end
    checks++; if (dec_mode !== 1'b0) begin errors++; $display("FAIL reset_dec got %b want 0", dec_mode); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst_n = 1'b1;
    exp_q.push_back(src0);
    tick();
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL reset_release_data got %h want %h", data, exp_v); end
    exp_page = 2'd0;
  endtask

  task automatic test_debounce();
    int seen;
    for (int i = 0; i < 30; i++) begin
      btn_next = ((i / 3) % 2 == 0);
      tick();
    end
    checks++; if (page !== exp_page) begin errors++; $display("FAIL bounce_no_step got %0d want %0d", page, exp_page); end
    btn_next = 1'b1;
    seen = 0;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      tick();
      if (page !== exp_page) seen = k;
    end
    exp_page = exp_page + 2'd1;
    checks++; if (seen < 17 || seen > 19) begin errors++; $display("FAIL debounce_latency got %0d want 18", seen); end
    checks++; if (page !== exp_page) begin errors++; $display("FAIL debounce_page got %0d want %0d", page, exp_page); end
    exp_q.push_back(src_of(exp_page));
    tick();
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL debounce_data got %h want %h", data, exp_v); end
    repeat (100) tick();
    checks++; if (page !== exp_page) begin errors++; $display("FAIL hold_single_pulse got %0d want %0d", page, exp_page); end
    btn_next = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_page_cycle();
    for (int s = 0; s < 3; s++) begin
      logic [1:0] prev;
      int seen;
      prev = exp_page;
      exp_page = exp_page + 2'd1;
      btn_next = 1'b1;
      seen = 0;
      for (int k = 1; k <= 30 && seen == 0; k++) begin
        tick();
        if (page !== prev) seen = k;
      end
      checks++; if (seen == 0 || page !== exp_page) begin errors++; $display("FAIL page_step got %0d want %0d", page, exp_page); end
      exp_q.push_back(src_of(exp_page));
      tick();
      exp_v = exp_q.pop_front();
      checks++; if (data !== exp_v) begin errors++; $display("FAIL page_data got %h want %h", data, exp_v); end
      repeat (10) tick();
      btn_next = 1'b0;
      repeat (25) tick();
    end
  endtask

  task automatic test_decimal();
    int seen;
    src0 = 32'h00BC614E;
    repeat (2) tick();
    btn_mode = 1'b1;
    seen = 0;
    for (int k = 1; k <= 30 && seen == 0; k++) begin
      tick();
      if (dec_mode === 1'b1) seen = k;
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL mode_enter got %b want 1", dec_mode); end
    exp_q.push_back(32'h1234_5678);
    seen = 0;
    for (int k = 1; k <= 36 && seen == 0; k++) begin
      tick();
      if (data !== 32'h00BC614E) seen = k;
    end
    checks++; if (seen == 0 || seen > 34) begin errors++; $display("FAIL dec_latency got %0d want 1..34", seen); end
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL dec_value got %h want %h", data, exp_v); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dec_ovf got %b want 0", ovf); end
    btn_mode = 1'b0;

    src0 = 32'd99999999;
    exp_q.push_back(32'h9999_9999);
    repeat (75) tick();
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL dec_max got %h want %h", data, exp_v); end

    src0 = 32'd100000000;
    exp_q.push_back(32'hFFFF_FFFF);
    repeat (75) tick();
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL dec_ovf_data got %h want %h", data, exp_v); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL dec_ovf_flag got %b want 1", ovf); end

    src0 = 32'hFFFF_FFFF;
    exp_q.push_back(32'hFFFF_FFFF);
    repeat (75) tick();
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL dec_allones_data got %h want %h", data, exp_v); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL dec_allones_flag got %b want 1", ovf); end
  endtask

  task automatic test_abort();
    int seen;
    src1 = 32'd87654321;
    src0 = 32'd11111111;
    seen = 0;
    for (int k = 1; k <= 80 && seen == 0; k++) begin
      tick();
      if (data !== 32'hFFFF_FFFF) seen = k;
    end
    checks++; if (data !== 32'h1111_1111) begin errors++; $display("FAIL abort_setup got %h want %h", data, 32'h1111_1111); end
    // Press lands 10 cycles into the SHIFT phase of the following conversion;
    // src0 is then changed so a missing abort would write a different word.
    seen = 0;
    for (int k = 1; k <= 120 && seen == 0; k++) begin
      if (k - 1 == 28) begin
        btn_next = 1'b1;
        exp_page = exp_page + 2'd1;
        exp_q.push_back(32'h8765_4321);
      end
      if (k - 1 == 34) src0 = 32'd22222222;
      if (k - 1 == 60) btn_next = 1'b0;
      tick();
      if (data !== 32'h1111_1111) seen = k;
    end
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL abort_next_result got %h want %h", data, exp_v); end
    checks++; if (page !== exp_page) begin errors++; $display("FAIL abort_page got %0d want %0d", page, exp_page); end
    btn_next = 1'b0;
    repeat (25) tick();

    btn_mode = 1'b1;
    seen = 0;
    for (int k = 1; k <= 30 && seen == 0; k++) begin
      tick();
      if (dec_mode === 1'b0) seen = k;
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL mode_leave got %b want 0", dec_mode); end
    exp_q.push_back(src_of(exp_page));
    tick();
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL leave_hex_data got %h want %h", data, exp_v); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL leave_ovf got %b want 0", ovf); end
    btn_mode = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_async_reset();
    int seen;
    btn_mode = 1'b1;
    seen = 0;
    for (int k = 1; k <= 30 && seen == 0; k++) begin
      tick();
      if (dec_mode === 1'b1) seen = k;
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL reenter_mode got %b want 1", dec_mode); end
    exp_q.push_back(32'h8765_4321);
    seen = 0;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      tick();
      if (data !== src1) seen = k;
    end
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL reenter_value got %h want %h", data, exp_v); end
    repeat (10) tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL async_data got %h want %h", data, 32'h0); end
    checks++; if (page !== 2'd0) begin errors++; $display("FAIL async_page got %0d want 0", page); end
    checks++; if (dec_mode !== 1'b0) begin errors++; $display("FAIL async_dec got %b want 0", dec_mode); end
    btn_mode = 1'b0;
    exp_page = 2'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    exp_q.push_back(src0);
    tick();
    exp_v = exp_q.pop_front();
    checks++; if (data !== exp_v) begin errors++; $display("FAIL async_release_data got %h want %h", data, exp_v); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_page_cycle();
    test_decimal();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
